regfile_master: RTL
===================

// Module: regfile_master
// PURPOSE
//  Initiator for the 32x32 register file write/read port pair. Accepts one bulk
//  command (FILL, COPY, CHECK), drives the file's write port and read port 1
//  one element per clock, and reports completion with a pulse.
//  Sits between a control/test sequencer and registerFile, replacing hand-driven
//  wrEnable/wrReg/wrData/rdReg1 sequences.
// PARAMETERS
//  (none; geometry is fixed: 32 entries, 5-bit address, 32-bit data)
// PORTS
//  clk          in   1   rising-edge clock, shared with the register file
//  rst          in   1   asynchronous, active-high reset
//  start        in   1   command strobe; sampled only in IDLE
//  op           in   2   0=FILL 1=COPY 2=CHECK 3=reserved
//  src_base     in   5   first read address (COPY, CHECK)
//  dst_base     in   5   first write address (FILL, COPY)
//  count        in   6   element count; 0 means no-op, values >32 clip to 32
//  fill_value   in   32  pattern start value (FILL, CHECK)
//  fill_step    in   32  pattern increment per element (FILL, CHECK)
//  busy         out  1   high while elements are being issued (RUN)
//  done         out  1   1-cycle pulse after the last element or a no-op/illegal command
//  cmd_err      out  1   valid with done: reserved or disabled op
//  err_count    out  6   CHECK mismatches, held until the next accepted start
//  rf_wrEnable  out  1   to registerFile.wrEnable
//  rf_wrReg     out  5   to registerFile.wrReg
//  rf_wrData    out  32  to registerFile.wrData
//  rf_rdReg1    out  5   to registerFile.rdReg1
//  rf_rdData1   in   32  from registerFile.rdData1 (combinational read)
// BEHAVIOUR
//  Reset, async: state=IDLE, busy=0, done=0, cmd_err=0, err_count=0,
//   rf_wrEnable=0, rf_wrReg=0, rf_wrData=0, rf_rdReg1=0, idx=0, acc=0.
//   rf_wrEnable drops immediately on rst. A partial operation is abandoned;
//   registers already written stay written.
//  FSM: IDLE -> RUN -> DONE -> IDLE.
//   IDLE: on start, latch op/bases/clipped count/fill_step and set acc=fill_value.
//    With count=0 or an illegal op, go straight to DONE (no writes).
//    Otherwise clear err_count and go to RUN with idx=0.
//   RUN: busy=1. Element idx addresses rd=src_base+idx and wr=dst_base+idx,
//    both mod 32 (wrap 31->0). On the last element (idx=N-1), go to DONE.
//   DONE: done=1 for exactly one cycle, busy=0, then IDLE.
//    cmd_err=1 in DONE only when the op is illegal.
//  start is ignored outside IDLE, including a start in the DONE cycle.
//  Per-element datapath (in RUN, combinational from the registered idx/acc):
//   FILL:  rf_wrEnable=1, rf_wrData=acc; at the edge, acc+=fill_step (mod 2^32).
//   COPY:  rf_wrEnable=1, rf_rdReg1=src, rf_wrData=rf_rdData1 (same-cycle pass-through).
//   CHECK: rf_wrEnable=0, rf_rdReg1=src. At the edge, err_count+=1 when
//    rf_rdData1!=acc; then acc+=fill_step.
//   Outside RUN, rf_wrEnable=0.
//  Timing: start sampled at edge 0. Element i commits at edge i+1. DONE is
//   the cycle after edge N, so busy is high for N cycles. A back-to-back
//   start is accepted at edge N+2 at the earliest.
//  COPY with overlap: elements are issued in ascending order. If dst_base is
//   inside (src_base, src_base+N), already-copied data propagates forward.
//   This is the defined behaviour, not an error.
//  err_count saturates at 32 and is stable from the DONE cycle onward.
// CONFIGURATION
//  RFM_CHECK_EN defined: op=2 performs CHECK as above.
//  RFM_CHECK_EN undefined: the CHECK datapath is removed. op=2 is illegal
//   (IDLE->DONE, done=1, cmd_err=1, no reads counted), and err_count stays 0.
// TESTING
//  T1 rst mid-RUN of FILL N=8: rf_wrEnable=0 at once, all outputs at reset values,
//   and a following start is accepted normally.
//  T2 FILL dst=0 N=10 value=0 step=2: regs 0..9 = 0,2,..18. busy high for 10 cycles,
//   then a single done pulse.
//  T3 COPY src=0 dst=20 N=10 after T2: regs 20..29 = 0..18. Then FILL dst=30 N=4
//   value=7 step=1: regs 30,31,0,1 = 7,8,9,10 (wrap).
//  T4 (RFM_CHECK_EN) CHECK src=2 N=8 value=4 step=2 on the T2 image: err_count=0.
//   Corrupt reg 5 and rerun: err_count=1.
//  T5 count=0, then op=3, then count=40: no writes with done+cmd_err=0; no writes
//   with done+cmd_err=1; exactly 32 writes.
//  T6 start held high through RUN and DONE: one command only. Without RFM_CHECK_EN,
//   op=2 gives cmd_err=1 and the register contents are unchanged.

Source files
------------

// File: rtl/regfile_master.sv
// ---------------------------------------------------------------------------
// regfile_master
//
// Bulk-command initiator for the 32x32 register file. One command is accepted
// at a time and walked one element per clock over the file's write port and
// read port 1:
//   FILL  : write an arithmetic pattern (fill_value, +fill_step ...) to dst
//   COPY  : copy src -> dst, ascending, through the combinational read port
//   CHECK : compare src against the pattern and count mismatches
//
// Build option:
//   RFM_CHECK_EN  defined   -> op=2 runs CHECK
//                 undefined -> op=2 is rejected like the reserved op=3
//
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   start             command strobe, only looked at in IDLE
//   op[1:0]           0=FILL 1=COPY 2=CHECK 3=reserved
//   src_base[4:0]     first read address (COPY, CHECK)
//   dst_base[4:0]     first write address (FILL, COPY)
//   count[5:0]        element count, 0 = no-op, above 32 clips to 32
//   fill_value[31:0]  pattern start value (FILL, CHECK)
//   fill_step[31:0]   pattern increment (FILL, CHECK)
//   busy              high while elements are issued
//   done              one-cycle completion pulse
//   cmd_err           qualifies done: the command was illegal
//   err_count[5:0]    CHECK mismatch count, saturates at 32
//   rf_wrEnable/rf_wrReg/rf_wrData   register file write port
//   rf_rdReg1/rf_rdData1             register file read port 1
// ---------------------------------------------------------------------------
module regfile_master (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [4:0]  src_base,
  input  logic [4:0]  dst_base,
  input  logic [5:0]  count,
  input  logic [31:0] fill_value,
  input  logic [31:0] fill_step,
  output logic        busy,
  output logic        done,
  output logic        cmd_err,
  output logic [5:0]  err_count,
  output logic        rf_wrEnable,
  output logic [4:0]  rf_wrReg,
  output logic [31:0] rf_wrData,
  output logic [4:0]  rf_rdReg1,
  input  logic [31:0] rf_rdData1
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [1:0] OP_FILL  = 2'd0;
  localparam logic [1:0] OP_COPY  = 2'd1;
  localparam logic [1:0] OP_CHECK = 2'd2;

  localparam logic [5:0] MAX_COUNT = 6'd32;

  state_t      state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [4:0]  src_q, src_d;
  logic [4:0]  dst_q, dst_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] step_q, step_d;
  logic [31:0] acc_q, acc_d;
  logic [4:0]  idx_q, idx_d;
  logic [5:0]  err_q, err_d;
  logic        illegal_q, illegal_d;

  logic        op_illegal;
  logic [5:0]  count_clipped;
  logic        last_elem;
  logic [4:0]  rd_addr;
  logic [4:0]  wr_addr;

  // Which incoming ops are refused depends on whether CHECK is built in.
  always_comb begin
`ifdef RFM_CHECK_EN
    op_illegal = (op == 2'd3);
`else
    op_illegal = (op == 2'd3) || (op == OP_CHECK);
`endif
  end

  assign count_clipped = (count > MAX_COUNT) ? MAX_COUNT : count;

  // cnt_q is 1..32 whenever RUN is active, so the subtraction cannot underflow.
  assign last_elem = ({1'b0, idx_q} == (cnt_q - 6'd1));

  // 5-bit sums give the mod-32 wrap for free.
  assign rd_addr = src_q + idx_q;
  assign wr_addr = dst_q + idx_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      op_q      <= 2'd0;
      src_q     <= 5'd0;
      dst_q     <= 5'd0;
      cnt_q     <= 6'd0;
      step_q    <= 32'd0;
      acc_q     <= 32'd0;
      idx_q     <= 5'd0;
      err_q     <= 6'd0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      cnt_q     <= cnt_d;
      step_q    <= step_d;
      acc_q     <= acc_d;
      idx_q     <= idx_d;
      err_q     <= err_d;
      illegal_q <= illegal_d;
    end
  end

  // Next-state logic. Command fields are captured once in IDLE so the caller
  // may change the inputs freely while the command runs.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    src_d     = src_q;
    dst_d     = dst_q;
    cnt_d     = cnt_q;
    step_d    = step_q;
    acc_d     = acc_q;
    idx_d     = idx_q;
    err_d     = err_q;
    illegal_d = illegal_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d      = op;
          src_d     = src_base;
          dst_d     = dst_base;
          cnt_d     = count_clipped;
          step_d    = fill_step;
          acc_d     = fill_value;
          idx_d     = 5'd0;
          illegal_d = op_illegal;
          if ((count == 6'd0) || op_illegal) begin
            // err_count from the previous command is deliberately kept.
            state_d = S_DONE;
          end else begin
            err_d   = 6'd0;
            state_d = S_RUN;
          end
        end
      end

      S_RUN: begin
        idx_d = idx_q + 5'd1;
        case (op_q)
          OP_FILL: acc_d = acc_q + step_q;
`ifdef RFM_CHECK_EN
          OP_CHECK: begin
            if ((rf_rdData1 != acc_q) && (err_q != MAX_COUNT)) begin
              err_d = err_q + 6'd1;
            end
            acc_d = acc_q + step_q;
          end
`endif
          default: ;
        endcase
        if (last_elem) begin
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Register-file port drive. Everything is idle-low outside RUN so the write
  // enable falls as soon as reset forces the state back to IDLE.
  always_comb begin
    rf_wrEnable = 1'b0;
    rf_wrReg    = 5'd0;
    rf_wrData   = 32'd0;
    rf_rdReg1   = 5'd0;

    if (state_q == S_RUN) begin
      case (op_q)
        OP_FILL: begin
          rf_wrEnable = 1'b1;
          rf_wrReg    = wr_addr;
          rf_wrData   = acc_q;
        end
        OP_COPY: begin
          // Same-cycle pass-through; with overlapping ranges earlier writes
          // are read back by later elements, which is intended.
          rf_wrEnable = 1'b1;
          rf_wrReg    = wr_addr;
          rf_rdReg1   = rd_addr;
          rf_wrData   = rf_rdData1;
        end
`ifdef RFM_CHECK_EN
        OP_CHECK: begin
          rf_rdReg1 = rd_addr;
        end
`endif
        default: ;
      endcase
    end
  end

  assign busy      = (state_q == S_RUN);
  assign done      = (state_q == S_DONE);
  assign cmd_err   = (state_q == S_DONE) && illegal_q;
  assign err_count = err_q;

endmodule
